// File: rtl/boxhead_pkg.sv
// rtl/boxhead_pkg.sv - frame geometry, SRAM widths, arbiter states and pixel-index helper
package boxhead_pkg;

  localparam int H_RES       = 640;
  localparam int V_RES       = 480;
  localparam int PIX_IDX_W   = 19;
  localparam int SRAM_ADDR_W = 20;
  localparam int PIX_DATA_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_RD_ADDR,
    ST_RD_CAP
  } sram_state_e;

  // 640 = 512 + 128, so the default geometry needs no multiplier.
  function automatic logic [PIX_IDX_W-1:0] pix_index(input logic [9:0] x, input logic [9:0] y,
                                                     input int h_res);
    logic [PIX_IDX_W-1:0] w_x;
    logic [PIX_IDX_W-1:0] w_y;
    w_x = {9'd0, x};
    w_y = {9'd0, y};
    if (h_res == 640) return (w_y << 9) + (w_y << 7) + w_x;
    return PIX_IDX_W'(int'(y) * h_res + int'(x));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a pop frees the slot for a same-cycle push when full
module sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/frame_write_buffer.sv
// rtl/frame_write_buffer.sv - buffers pixel writes and arbitrates the SRAM port against display reads
module frame_write_buffer
  import boxhead_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int H_RES      = boxhead_pkg::H_RES,
  parameter int V_RES      = boxhead_pkg::V_RES
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   program_write,
  input  logic [9:0]             program_x,
  input  logic [9:0]             program_y,
  input  logic [PIX_DATA_W-1:0]  program_data,
  input  logic [1:0]             palette_index,
  input  logic                   swap_req,
  input  logic                   vblank,
  input  logic                   rd_req,
  input  logic [PIX_IDX_W-1:0]   rd_addr,
  output logic [PIX_DATA_W-1:0]  rd_data,
  output logic                   rd_valid,
  output logic [1:0]             front_palette,
  output logic                   front_sel,
  output logic                   swap_done,
  output logic                   overflow,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [PIX_DATA_W-1:0]  SRAM_DQ,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam int ENTRY_W = PIX_IDX_W + PIX_DATA_W;

  sram_state_e           r_state;
  logic                  r_swap_pending;
  logic [1:0]            r_back_palette;
  logic                  r_dq_oe;
  logic [PIX_DATA_W-1:0] r_dq_out;

  logic                  w_in_range;
  logic                  w_push_req;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_swap_go;
  logic [ENTRY_W-1:0]    w_fifo_din;
  logic [ENTRY_W-1:0]    w_fifo_dout;
  logic [PIX_IDX_W-1:0]  w_head_idx;
  logic [PIX_DATA_W-1:0] w_head_data;

  assign w_in_range = (int'(program_x) < H_RES) && (int'(program_y) < V_RES);
  assign w_push_req = program_write && w_in_range;
  assign w_accept   = w_push_req && (!w_full || w_pop);
  assign w_fifo_din = {pix_index(program_x, program_y, H_RES), program_data};
  assign {w_head_idx, w_head_data} = w_fifo_dout;

  // Swap beats a pending read, and a read beats a queued write.
  assign w_swap_go = (r_state == ST_IDLE) && r_swap_pending && w_empty && vblank;
  assign w_pop     = (r_state == ST_IDLE) && !w_swap_go && !rd_req && !w_empty;

  assign SRAM_DQ = r_dq_oe ? r_dq_out : 'z;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_data  (w_fifo_din),
    .o_data  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      overflow       <= 1'b0;
      r_back_palette <= 2'd0;
      r_swap_pending <= 1'b0;
    end else begin
      if (w_push_req && !w_accept) overflow <= 1'b1;
      if (w_accept) r_back_palette <= palette_index;
      if (w_swap_go)     r_swap_pending <= 1'b0;
      else if (swap_req) r_swap_pending <= 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= ST_IDLE;
      SRAM_ADDR     <= '0;
      SRAM_WE_N     <= 1'b1;
      SRAM_OE_N     <= 1'b1;
      SRAM_CE_N     <= 1'b1;
      SRAM_UB_N     <= 1'b1;
      SRAM_LB_N     <= 1'b1;
      r_dq_oe       <= 1'b0;
      r_dq_out      <= '0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      swap_done     <= 1'b0;
      front_sel     <= 1'b0;
      front_palette <= 2'd0;
    end else begin
      rd_valid  <= 1'b0;
      swap_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_swap_go) begin
            front_sel     <= ~front_sel;
            front_palette <= r_back_palette;
            swap_done     <= 1'b1;
          end else if (rd_req) begin
            SRAM_ADDR <= {front_sel, rd_addr};
            SRAM_CE_N <= 1'b0;
            SRAM_OE_N <= 1'b0;
            SRAM_UB_N <= 1'b0;
            SRAM_LB_N <= 1'b0;
            r_state   <= ST_RD_ADDR;
          end else if (w_pop) begin
            SRAM_ADDR <= {~front_sel, w_head_idx};
            r_dq_out  <= w_head_data;
            r_dq_oe   <= 1'b1;
            SRAM_CE_N <= 1'b0;
            SRAM_UB_N <= 1'b0;
            SRAM_LB_N <= 1'b0;
            r_state   <= ST_WR_SETUP;
          end
        end
        ST_WR_SETUP: begin
          SRAM_WE_N <= 1'b0;
          r_state   <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          SRAM_WE_N <= 1'b1;
          SRAM_CE_N <= 1'b1;
          SRAM_UB_N <= 1'b1;
          SRAM_LB_N <= 1'b1;
          r_dq_oe   <= 1'b0;
          r_state   <= ST_IDLE;
        end
        ST_RD_ADDR: begin
          r_state <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          rd_data   <= SRAM_DQ;
          rd_valid  <= 1'b1;
          SRAM_CE_N <= 1'b1;
          SRAM_OE_N <= 1'b1;
          SRAM_UB_N <= 1'b1;
          SRAM_LB_N <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_write_buffer.sv
// tb/tb_frame_write_buffer.sv - randomized scoreboard bench for frame_write_buffer
module tb_frame_write_buffer;

  localparam int HR = 640;
  localparam int VR = 480;

  typedef struct packed {
    logic [19:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        program_write = 1'b0;
  logic [9:0]  program_x = '0;
  logic [9:0]  program_y = '0;
  logic [15:0] program_data = '0;
  logic [1:0]  palette_index = '0;
  logic        swap_req = 1'b0;
  logic        vblank = 1'b0;
  logic        rd_req = 1'b0;
  logic [18:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [1:0]  front_palette;
  logic        front_sel;
  logic        swap_done;
  logic        overflow;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;

  always #10 clk = ~clk;

  frame_write_buffer dut (
    .Clk           (clk),
    .Reset         (rst),
    .program_write (program_write),
    .program_x     (program_x),
    .program_y     (program_y),
    .program_data  (program_data),
    .palette_index (palette_index),
    .swap_req      (swap_req),
    .vblank        (vblank),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .front_palette (front_palette),
    .front_sel     (front_sel),
    .swap_done     (swap_done),
    .overflow      (overflow),
    .SRAM_ADDR     (sram_addr),
    .SRAM_DQ       (sram_dq),
    .SRAM_WE_N     (we_n),
    .SRAM_OE_N     (oe_n),
    .SRAM_CE_N     (ce_n),
    .SRAM_UB_N     (ub_n),
    .SRAM_LB_N     (lb_n)
  );

  // Power-up content of the SRAM, shared by the SRAM model and the reference.
  function automatic logic [15:0] bg(input logic [19:0] a);
    return a[15:0] ^ 16'h5A3C ^ {a[19:16], 12'h000};
  endfunction

  logic [15:0] sram_mem [bit [19:0]];
  logic [15:0] sram_rd = '0;

  always @(negedge clk) begin
    if (!ce_n && !we_n) sram_mem[sram_addr] = sram_dq;
    sram_rd = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : bg(sram_addr);
  end
  assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_rd : 16'hzzzz;

  logic [15:0] ref_mem [bit [19:0]];
  logic        m_front = 1'b0;
  logic [1:0]  m_back_pal = 2'd0;
  wr_t         wq[$];
  logic [15:0] rq[$];
  logic [2:0]  sq[$];
  logic        rd_hold = 1'b0;
  logic [15:0] rd_hold_exp = '0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          we_len = 0;
  int          wr_seen = 0;
  int          swap_cnt = 0;
  wr_t         e_w;
  logic [2:0]  e_s;

  function automatic logic [15:0] ref_val(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : bg(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Write monitor: every WE_N low pulse must match the next queued write.
  always @(negedge clk) begin
    if (!we_n) begin
      if (we_len == 0) begin
        wr_seen++;
        if (wq.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          e_w = wq.pop_front();
          chk("wr_addr", sram_addr, e_w.a);
          chk("wr_data", sram_dq, e_w.d);
          chk("wr_oe_n", oe_n, 1);
          chk("wr_ce_n", ce_n, 0);
        end
      end
      we_len++;
    end else if (we_len > 0) begin
      chk("we_pulse_len", we_len, 1);
      we_len = 0;
    end
  end

  always @(negedge clk) begin
    if (rd_valid) begin
      if (rq.size() > 0) chk("rd_data", rd_data, rq.pop_front());
      else if (rd_hold) chk("rd_data_hold", rd_data, rd_hold_exp);
      else chk("rd_unexpected", 1, 0);
    end
    if (swap_done) begin
      swap_cnt++;
      if (sq.size() == 0) chk("swap_unexpected", 1, 0);
      else begin
        e_s = sq.pop_front();
        chk("swap_front_sel", front_sel, e_s[2]);
        chk("swap_front_pal", front_palette, e_s[1:0]);
      end
    end
  end

  task automatic do_write(input int x, input int y, input logic [15:0] d, input logic [1:0] pal,
                          input bit drop);
    logic [19:0] a;
    program_x = 10'(x);
    program_y = 10'(y);
    program_data = d;
    palette_index = pal;
    program_write = 1'b1;
    if (x < HR && y < VR && !drop) begin
      a = {~m_front, 19'(y * HR + x)};
      wq.push_back('{a, d});
      ref_mem[a] = d;
      m_back_pal = pal;
    end
    @(posedge clk); #1;
    program_write = 1'b0;
  endtask

  task automatic do_read(input logic [18:0] a);
    bit seen;
    seen = 0;
    rd_addr = a;
    rd_req = 1'b1;
    rq.push_back(ref_val({m_front, a}));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rd_valid) begin seen = 1; break; end
    end
    rd_req = 1'b0;
    if (!seen) chk("rd_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && wq.size() != 0; i++) @(posedge clk);
    chk("drain_left", wq.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic rand_phase(input int n);
    int r, x, y;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        x = ($urandom_range(0, 19) == 0) ? HR + $urandom_range(0, 300) : $urandom_range(0, HR - 1);
        y = ($urandom_range(0, 19) == 0) ? VR + $urandom_range(0, 500) : $urandom_range(0, VR - 1);
        do_write(x, y, 16'($urandom), 2'($urandom_range(0, 3)), 0);
        repeat ($urandom_range(3, 5)) @(posedge clk);
        #1;
      end else if (r < 9) begin
        do_read(19'($urandom_range(0, HR * VR - 1)));
      end else begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    int seen0, prev;
    bit found;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_we_n", we_n, 1);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_ce_n", ce_n, 1);
    chk("rst_ublb_n", {ub_n, lb_n}, 2'b11);
    chk("rst_addr", sram_addr, 0);
    chk("rst_rd", {rd_valid, rd_data}, 0);
    chk("rst_flags", {swap_done, overflow, front_sel, front_palette}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    do_write(3, 2, 16'hBEEF, 2'd1, 0);
    wait_drain();

    seen0 = wr_seen;
    do_write(640, 0, 16'h1111, 2'd3, 0);
    do_write(0, 480, 16'h2222, 2'd3, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("range_no_write", wr_seen - seen0, 0);
    chk("range_overflow", overflow, 0);

    rd_addr = 19'd5;
    rd_req = 1'b1;
    rq.push_back(ref_val({m_front, 19'd5}));
    do_write(7, 9, 16'hC0DE, 2'd1, 0);
    @(negedge clk);
    chk("prio_addr", sram_addr, {m_front, 19'd5});
    chk("prio_oe_we", {oe_n, we_n}, 2'b01);
    @(negedge clk);
    chk("prio_early_valid", rd_valid, 0);
    @(negedge clk);
    chk("prio_latency", rd_valid, 1);
    rd_req = 1'b0;
    @(posedge clk); #1;
    wait_drain();

    rand_phase(40);
    wait_drain();

    seen0 = wr_seen;
    rd_addr = 19'd7;
    rd_hold_exp = ref_val({m_front, 19'd7});
    rd_hold = 1'b1;
    rd_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) do_write(i * 3, 100 + i, 16'h1000 + 16'(i), (i == 16) ? 2'd3 : 2'd1, i == 16);
    chk("ovf_set", overflow, 1);
    rd_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rd_hold = 1'b0;
    wait_drain();
    chk("ovf_write_count", wr_seen - seen0, 16);

    prev = swap_cnt;
    do_write(20, 30, 16'hA001, 2'd2, 0);
    do_write(21, 30, 16'hA002, 2'd2, 0);
    swap_req = 1'b1;
    do_write(22, 30, 16'hA003, 2'd2, 0);
    swap_req = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("swap_held_cnt", swap_cnt - prev, 0);
    chk("swap_held_front", front_sel, m_front);
    sq.push_back({~m_front, m_back_pal});
    vblank = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (swap_cnt != prev) begin found = 1; break; end
    end
    chk("swap_seen", found, 1);
    m_front = ~m_front;
    vblank = 1'b0;
    @(posedge clk); #1;
    do_write(5, 5, 16'h5555, 2'd0, 0);
    do_read(19'd1283);
    wait_drain();

    rand_phase(40);
    wait_drain();

    do_write(10, 10, 16'h1234, 2'd1, 0);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!we_n) begin found = 1; break; end
    end
    chk("rst_reach_pulse", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_we_n", we_n, 1);
    chk("rst_mid_ce_oe", {ce_n, oe_n}, 2'b11);
    chk("rst_mid_dq_oe", dut.r_dq_oe, 0);
    m_front = 1'b0;
    m_back_pal = 2'd0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_front", front_sel, m_front);
    chk("post_rst_ovf", overflow, 0);
    chk("post_rst_pal", front_palette, 0);
    seen0 = wr_seen;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_fifo_empty", wr_seen - seen0, 0);

    chk("end_wq", wq.size(), 0);
    chk("end_rq", rq.size(), 0);
    chk("end_sq", sq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
